// File: rtl/pic_reader.sv
// Streams one 32x32 frame from a 1-cycle-latency image ROM into a 4-entry
// registered FIFO, presented to the consumer with a valid/ready handshake.
`ifndef WD
`define WD 8
`endif

module pic_reader #(
  parameter int WD    = `WD,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [9:0]    aa,
  output logic          cena,
  input  logic [WD-1:0] qa,
  output logic [WD-1:0] pix_data,
  output logic [4:0]    pix_row,
  output logic [4:0]    pix_col,
  output logic          pix_last,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          busy,
  output logic          done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  typedef struct packed {
    logic          last;
    logic [4:0]    row;
    logic [4:0]    col;
    logic [WD-1:0] data;
  } ent_t;

  state_e                 state_q, state_d;
  logic [9:0]             addr_q, addr_d;
  logic                   inflt_q, inflt_d;
  logic [9:0]             iaddr_q, iaddr_d;
  logic [PW-1:0]          wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  ent_t [DEPTH-1:0]       mem_q, mem_d;

  logic [CW:0] occ;
  logic        credit_ok, issue, push, pop;
  ent_t        head;

  // Credits cover both stored entries and the read still in the ROM pipe,
  // so a returning word always has a free slot.
  assign occ       = {1'b0, cnt_q} + {{CW{1'b0}}, inflt_q};
  assign credit_ok = occ < (CW+1)'(DEPTH);
  assign issue     = ~cena;
  assign push      = inflt_q;
  assign pop       = pix_valid & pix_ready;
  assign head      = mem_q[rp_q];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (issue && addr_q == 10'h3FF) state_d = DRAIN;
      DRAIN:   if (pop && head.last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cena = 1'b1;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      READ:  begin busy = 1'b1; cena = ~credit_ok; end
      DRAIN: busy = 1'b1;
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Address counter, in-flight tracking and FIFO
  always_comb begin
    addr_d  = addr_q;
    inflt_d = issue;
    iaddr_d = iaddr_q;
    mem_d   = mem_q;
    if (state_q == IDLE && start) addr_d = '0;
    else if (issue)               addr_d = addr_q + 10'd1;
    if (issue) iaddr_d = addr_q;
    if (push) mem_d[wp_q] = '{last: (iaddr_q == 10'h3FF), row: iaddr_q[9:5],
                              col: iaddr_q[4:0], data: qa};
    wp_d  = wp_q + PW'(push);
    rp_d  = rp_q + PW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      inflt_q <= 1'b0;
      iaddr_q <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      mem_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      inflt_q <= inflt_d;
      iaddr_q <= iaddr_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  assign aa        = addr_q;
  assign pix_valid = (cnt_q != '0);
  // Head fields are masked when empty so reset shows zeros immediately.
  assign pix_data  = pix_valid ? head.data : '0;
  assign pix_row   = pix_valid ? head.row  : '0;
  assign pix_col   = pix_valid ? head.col  : '0;
  assign pix_last  = pix_valid & head.last;

endmodule

// File: tb/tb_pic_reader.sv
// Directed bench for pic_reader: ROM model, expected-pixel queue per frame,
// credit/address model and stall-stability checks.
module tb_pic_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] aa;
  logic       cena;
  logic [7:0] qa = 8'h00;
  logic [7:0] pix_data;
  logic [4:0] pix_row, pix_col;
  logic       pix_last, pix_valid, busy, done;
  logic       pix_ready = 1'b0;

  typedef struct packed {
    logic       l;
    logic [4:0] r;
    logic [4:0] c;
    logic [7:0] d;
  } pix_t;

  pix_t exp_q[$];
  logic [7:0] rom [1024];
  int n_cmp = 0;
  int n_err = 0;

  pic_reader #(.WD(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .aa(aa), .cena(cena), .qa(qa),
    .pix_data(pix_data), .pix_row(pix_row), .pix_col(pix_col),
    .pix_last(pix_last), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 1024; i++) rom[i] = i[7:0];
  always @(posedge clk) if (!cena) qa <= rom[aa];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready=1, 1: random ready, 2: random + stray starts,
  // 3: ready low for 20 cycles, 4: abort after 100 transfers
  task automatic run_frame(input int mode);
    int   issued, xfers, dones, last_cyc;
    bit   rdy, pv, pr, seen, dpulse;
    pix_t hold, cur, e;
    issued = 0; xfers = 0; dones = 0; last_cyc = 0;
    pv = 0; pr = 0; seen = 0; dpulse = 0; hold = '0;
    exp_q.delete();
    for (int i = 0; i < 1024; i++) begin
      e.d = i[7:0]; e.r = i[9:5]; e.c = i[4:0]; e.l = (i == 1023);
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b1;
    pix_ready = 1'b1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      case (mode)
        1, 2:    rdy = 1'($urandom_range(0, 1));
        3:       rdy = (cyc >= 20);
        default: rdy = 1'b1;
      endcase
      cur = {pix_last, pix_row, pix_col, pix_data};
      if (pv && !pr) chk("stall_stable", 32'(cur), 32'(hold));
      chk("cena_credit", 32'(cena),
          32'(!(busy && issued < 1024 && (issued - xfers) < 4)));
      if (!cena) chk("aa_order", 32'(aa), 32'(issued));
      if (mode == 0) chk("valid_stream", 32'(pix_valid), 32'(cyc >= 2 && xfers < 1024));
      if (mode == 3 && cyc == 20) chk("stall_reads", 32'(issued), 32'd4);
      if (seen) begin
        chk("done_width", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        break;
      end
      if (done) begin
        dones++;
        seen = 1;
        chk("done_xfers", 32'(xfers), 32'd1024);
        chk("done_timing", 32'(cyc), 32'(last_cyc + 1));
        chk("busy_in_done", 32'(busy), 32'd0);
      end
      if (mode == 2 && (cyc == 10 || (issued == 1024 && !dpulse && xfers < 1024))) begin
        start = 1'b1;
        if (issued == 1024) dpulse = 1;
      end
      pix_ready = rdy;
      if (pix_valid && rdy) begin
        chk("underflow", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pixel", 32'(cur), 32'(e));
        end
        xfers++;
        last_cyc = cyc;
      end
      if (!cena) issued++;
      pv = pix_valid;
      pr = rdy;
      hold = cur;
      if (mode == 4 && xfers == 100) return;
    end
    chk("frame_end_seen", 32'(seen), 32'd1);
    chk("single_done", 32'(dones), 32'd1);
    chk("xfer_total", 32'(xfers), 32'd1024);
    if (mode == 2) begin
      chk("drain_start_hit", 32'(dpulse), 32'd1);
      repeat (3) begin
        @(negedge clk);
        chk("idle_no_restart", 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    #12;
    chk("rst_cena", 32'(cena), 32'd1);
    chk("rst_aa", 32'(aa), 32'd0);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_data", 32'({pix_last, pix_row, pix_col, pix_data}), 32'd0);
    chk("rst_busy_done", 32'({busy, done}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(0);
    run_frame(3);
    run_frame(1);
    run_frame(2);

    run_frame(4);
    #1 rst_n = 1'b0;
    #1;
    chk("async_cena", 32'(cena), 32'd1);
    chk("async_aa", 32'(aa), 32'd0);
    chk("async_valid", 32'(pix_valid), 32'd0);
    chk("async_data", 32'({pix_last, pix_row, pix_col, pix_data}), 32'd0);
    chk("async_busy_done", 32'({busy, done}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
